// File: rtl/ext_pkg.sv
// Shared types for the immediate-extension unit: extension modes and
// prefix-tracking FSM states.
package ext_pkg;

    typedef enum logic [1:0] {
        EXT_SIGN = 2'b00,
        EXT_ZERO = 2'b01,
        EXT_LEFT = 2'b10,
        EXT_RSVD = 2'b11
    } ext_mode_t;

    typedef enum logic {
        IDLE     = 1'b0,
        PFX_HELD = 1'b1
    } pfx_state_t;

endpackage

// File: rtl/ext_core.sv
// Combinational mode mux: widens a raw operand to the full data width.
// The reserved mode behaves like zero extension.
module ext_core
    import ext_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int OPERAND_WIDTH = 11
) (
    input  logic [OPERAND_WIDTH-1:0] data_in,
    input  logic [1:0]               mode_in,
    output logic [DATA_WIDTH-1:0]    ext_out
);

    localparam int PFX_WIDTH = DATA_WIDTH - OPERAND_WIDTH;

    // Select the fill pattern for the bits the operand does not cover.
    always_comb begin
        ext_out = '0;
        case (ext_mode_t'(mode_in))
            EXT_SIGN: ext_out = {{PFX_WIDTH{data_in[OPERAND_WIDTH-1]}}, data_in};
            EXT_LEFT: ext_out = {data_in, {PFX_WIDTH{1'b0}}};
            default:  ext_out = {{PFX_WIDTH{1'b0}}, data_in};
        endcase
    end

endmodule

// File: rtl/imm_ext_unit.sv
// Pipelined immediate extender. A prefix word supplies the upper bits of
// the next operand; the result sits in a one-deep output register with a
// valid/ready handshake on both sides.
//
//   state    | meaning
//   ---------+----------------------------------------------------
//   IDLE     | no prefix held; next data word is mode-extended
//   PFX_HELD | pfx_reg holds upper bits for the next data word
module imm_ext_unit
    import ext_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int OPERAND_WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [OPERAND_WIDTH-1:0] data_in,
    input  logic [1:0]               mode_in,
    input  logic                     pfx_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    ext_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic                     pfx_active
);

    localparam int PFX_WIDTH = DATA_WIDTH - OPERAND_WIDTH;

    pfx_state_t             state_q, state_d;
    logic [PFX_WIDTH-1:0]   pfx_reg;
    logic [PFX_WIDTH-1:0]   pfx_next;
    logic [DATA_WIDTH-1:0]  core_out;
    logic [DATA_WIDTH-1:0]  result;
    logic                   accept;
    logic                   load_pfx;
    logic                   load_out;

    assign ready_out  = !valid_out || ready_in;
    assign accept     = valid_in && ready_out;
    assign pfx_active = (state_q == PFX_HELD);

    // A prefix can be wider than the operand for some parameter choices;
    // in that case its upper bits come in as zero.
    if (PFX_WIDTH <= OPERAND_WIDTH) begin : g_pfx_slice
        assign pfx_next = data_in[PFX_WIDTH-1:0];
    end else begin : g_pfx_pad
        assign pfx_next = PFX_WIDTH'(data_in);
    end

    ext_core #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPERAND_WIDTH (OPERAND_WIDTH)
    ) u_core (
        .data_in (data_in),
        .mode_in (mode_in),
        .ext_out (core_out)
    );

    // With a prefix held the mode is ignored and the prefix forms the top bits.
    assign result = (state_q == PFX_HELD) ? {pfx_reg, data_in} : core_out;

    // Prefix FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and load strobes; flush wins over a coincident accept.
    always_comb begin
        state_d  = state_q;
        load_pfx = 1'b0;
        load_out = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            if (pfx_in) begin
                load_pfx = 1'b1;
                state_d  = PFX_HELD;
            end else begin
                load_out = 1'b1;
                state_d  = IDLE;
            end
        end
    end

    // Held prefix bits; cleared on flush so a stale prefix never lingers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           pfx_reg <= '0;
        else if (flush)    pfx_reg <= '0;
        else if (load_pfx) pfx_reg <= pfx_next;
    end

    // Output register: load a new result, else drain when downstream takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_out   <= '0;
            valid_out <= 1'b0;
        end else if (flush) begin
            valid_out <= 1'b0;
        end else if (load_out) begin
            ext_out   <= result;
            valid_out <= 1'b1;
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_ext_unit.sv
// Directed bench for imm_ext_unit: the driver pushes each expected result
// into a queue on accept, and a monitor pops and compares on every
// output handshake.
module tb_imm_ext_unit;

    localparam int DW = 16;
    localparam int OW = 11;

    localparam logic [1:0] M_SIGN = 2'b00;
    localparam logic [1:0] M_ZERO = 2'b01;
    localparam logic [1:0] M_LEFT = 2'b10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [OW-1:0] data_in = '0;
    logic [1:0]    mode_in = '0;
    logic          pfx_in = 1'b0;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic          flush = 1'b0;
    logic [DW-1:0] ext_out;
    logic          valid_out;
    logic          ready_in = 1'b1;
    logic          pfx_active;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    imm_ext_unit #(.DATA_WIDTH(DW), .OPERAND_WIDTH(OW)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .mode_in    (mode_in),
        .pfx_in     (pfx_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .flush      (flush),
        .ext_out    (ext_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .pfx_active (pfx_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && valid_out && ready_in) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got=%h expected=none at %0t", ext_out, $time);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (ext_out !== e) begin
                    failures++;
                    $display("FAIL result got=%h expected=%h at %0t", ext_out, e, $time);
                end
            end
        end
    end

    // Present one word (called just after a rising edge) and hold it until
    // accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [OW-1:0] d, input logic [1:0] m, input logic p,
                        input logic has_exp, input logic [DW-1:0] exp);
        int tries = 0;
        logic done = 1'b0;
        data_in  = d;
        mode_in  = m;
        pfx_in   = p;
        valid_in = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (ready_out) begin
                if (has_exp) exp_q.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            tries++;
            if (!done && tries > 50) begin
                checks++;
                failures++;
                $display("FAIL send_timeout got=stalled expected=accept data=%h", d);
                done = 1'b1;
            end
        end
        valid_in = 1'b0;
        pfx_in   = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ext_out",    32'(ext_out),    32'h0);
        check("reset_valid_out",  32'(valid_out),  32'h0);
        check("reset_pfx_active", 32'(pfx_active), 32'h0);
        check("reset_ready_out",  32'(ready_out),  32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Modes, one cycle latency, then back-to-back throughput.
        send(11'b10000000001, M_SIGN, 1'b0, 1'b1, 16'hFC01);
        check("latency_valid", 32'(valid_out), 32'h1);
        check("latency_data",  32'(ext_out),   32'hFC01);
        send(11'b10000000001, M_ZERO, 1'b0, 1'b1, 16'h0401);
        send(11'b00011000110, M_LEFT, 1'b0, 1'b1, 16'h18C0);
        send(11'h123, 2'b11, 1'b0, 1'b1, 16'h0123);
        repeat (2) @(posedge clk); #1;

        // Prefix then data; mode ignored while a prefix is held.
        send(11'h015, M_SIGN, 1'b1, 1'b0, '0);
        check("pfx_active_held", 32'(pfx_active), 32'h1);
        check("pfx_no_output",   32'(valid_out),  32'h0);
        send(11'h0C6, M_LEFT, 1'b0, 1'b1, 16'hA8C6);
        check("pfx_active_clear", 32'(pfx_active), 32'h0);
        repeat (2) @(posedge clk); #1;

        // Double prefix: the second overwrites the first.
        send(11'h01F, M_ZERO, 1'b1, 1'b0, '0);
        send(11'h001, M_ZERO, 1'b1, 1'b0, '0);
        check("dbl_pfx_active", 32'(pfx_active), 32'h1);
        send(11'h000, M_ZERO, 1'b0, 1'b1, 16'h0800);
        repeat (2) @(posedge clk); #1;

        // Back-pressure: result held stable, input stalled, then back-to-back.
        ready_in = 1'b0;
        send(11'b11000000111, M_SIGN, 1'b0, 1'b1, 16'hFE07);
        fork
            send(11'h0C6, M_ZERO, 1'b0, 1'b1, 16'h00C6);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_hold_data",  32'(ext_out),   32'hFE07);
                    check("bp_hold_valid", 32'(valid_out), 32'h1);
                    check("bp_ready_out",  32'(ready_out), 32'h0);
                end
                @(posedge clk); #1;
                ready_in = 1'b1;
            end
        join
        check("b2b_valid", 32'(valid_out), 32'h1);
        check("b2b_data",  32'(ext_out),   32'h00C6);
        repeat (2) @(posedge clk); #1;

        // Flush with a held prefix and a coincident data word.
        send(11'h01F, M_SIGN, 1'b1, 1'b0, '0);
        data_in  = 11'h123;
        mode_in  = M_ZERO;
        pfx_in   = 1'b0;
        valid_in = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        valid_in = 1'b0;
        check("flush_pfx_active", 32'(pfx_active), 32'h0);
        check("flush_valid_out",  32'(valid_out),  32'h0);
        send(11'h607, M_ZERO, 1'b0, 1'b1, 16'h0607);
        repeat (2) @(posedge clk); #1;

        // Async reset between edges while a prefix is held.
        send(11'h015, M_SIGN, 1'b1, 1'b0, '0);
        check("pre_rst_pfx_active", 32'(pfx_active), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pfx_active", 32'(pfx_active), 32'h0);
        check("async_rst_ext_out",    32'(ext_out),    32'h0);
        check("async_rst_valid_out",  32'(valid_out),  32'h0);
        check("async_rst_ready_out",  32'(ready_out),  32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        send(11'h0C6, M_SIGN, 1'b0, 1'b1, 16'h00C6);

        repeat (4) @(posedge clk); #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
